branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch decision logic in the core.
- Resolves conditional branches in EX using full signed/unsigned compare flags, not only the zero flag.
- Keeps a PC-indexed table of 2-bit saturating counters. The fetch stage reads it for a taken/not-taken prediction.
- Flags mispredictions, drives redirect/pc_sel, and keeps saturating performance counters readable by the CSR block.

Parameters:
- XLEN, 32, PC width.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, minimum 2.
- IDX_LSB, 2, lowest PC bit used for the table index. Index = pc[IDX_LSB +: log2(BHT_ENTRIES)].
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- if_pc  in  XLEN  fetch-stage PC used for lookup
- if_pred_taken  out  1  prediction for if_pc: MSB of the indexed counter (combinational)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_stall  in  1  EX stage is held this cycle
- ex_pc  in  XLEN  PC of the EX instruction
- ex_fun3  in  3  branch funct3: BEQ=0, BNE=1, BLT=4, BGE=5, BLTU=6, BGEU=7
- ex_branch  in  1  conditional branch
- ex_jump  in  1  JAL/JALR
- ex_zero  in  1  ALU result zero (rs1==rs2)
- ex_less  in  1  rs1<rs2, signed
- ex_lessu  in  1  rs1<rs2, unsigned
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- pc_sel  out  1  actual control transfer taken (jump, or branch resolved taken)
- mispredict  out  1  conditional-branch outcome differs from ex_pred_taken
- redirect  out  1  front end must be flushed and refetched
- redirect_seq  out  1  with redirect: refetch at ex_pc+4 (predicted taken, actually not taken)
- branch_cnt  out  CNT_W  resolved conditional branches
- mispred_cnt  out  CNT_W  mispredicted conditional branches

Behaviour:
- Resolved outcome `taken`:
  - BEQ = zero; BNE = ~zero.
  - BLT = less; BGE = ~less.
  - BLTU = lessu; BGEU = ~lessu.
  - fun3 2 or 3 gives taken=0.
- Combinational outputs, all gated by ex_valid; ex_stall does not gate them:
  - pc_sel = ex_valid & (ex_jump | (ex_branch & taken)).
  - mispredict = ex_valid & ex_branch & ~ex_jump & (taken != ex_pred_taken).
  - redirect = ex_valid & ex_jump | mispredict.
  - redirect_seq = mispredict & ~taken.
- If ex_jump and ex_branch are both high, jump has priority: no mispredict, no table update, no counter increment.
- Commit: `commit = ex_valid & ~ex_stall & ex_branch & ~ex_jump & (ex_fun3 not 2/3)`.
- Table update, on rising clk when commit:
  - counter[idx(ex_pc)] increments if taken, decrements otherwise.
  - Saturates at 2'b11 and 2'b00.
- Read/write same cycle:
  - if_pred_taken shows the pre-update value; no bypass.
  - A write and a read of the same index in one cycle returns the old value. The new value is visible the next cycle.
- Perf counters, on commit:
  - branch_cnt += 1.
  - mispred_cnt += 1 if mispredict.
  - Both saturate at all-ones; they do not wrap.
- Aliasing: PCs sharing index bits share one counter. This is intended.
- Reset (async, active-high):
  - all table entries = CTR_INIT; branch_cnt = 0; mispred_cnt = 0.
  - Combinational outputs follow their inputs: pc_sel, mispredict, redirect, redirect_seq are 0 when ex_valid=0.
  - Reset asserted mid-run discards any in-progress update.
  - During reset, if_pred_taken = CTR_INIT[1].
- Latency:
  - prediction: 0 cycles.
  - resolution outputs: 0 cycles.
  - table and counter effect: 1 cycle.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0. Commit 2 taken BEQs (ex_zero=1) at ex_pc=0x100 -> counter 01→10→11, if_pred_taken=1 from the cycle after the first commit.
- Counter at 11, 3 not-taken BNE (ex_zero=1) at 0x100 -> counter 11→10→01→00. A 4th not-taken commit stays at 00.
- BLT with ex_less=1, ex_pred_taken=0 -> pc_sel=1, mispredict=1, redirect=1, redirect_seq=0, mispred_cnt +1. BGEU with ex_lessu=0, ex_pred_taken=1 -> mispredict=0, pc_sel=1.
- BLTU with ex_lessu=0, ex_pred_taken=1 -> redirect=1, redirect_seq=1.
- ex_stall=1 for 3 cycles on a taken branch -> table and branch_cnt unchanged until the first unstalled cycle, then exactly +1.
- JAL (ex_jump=1, ex_branch=1) -> pc_sel=1, redirect=1, mispredict=0, no counter change.
- fun3=2 -> pc_sel=0, no update.
- Force branch_cnt to all-ones minus 1, then commit 2 branches -> saturates at all-ones.
- Assert reset mid-sequence -> all entries return to CTR_INIT and counters read 0 in the same cycle.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch resolution and bimodal prediction: resolves EX-stage branches with full compare flags and predicts with 2-bit counters.
// Latency: prediction and resolution outputs are combinational (0 cycles); table and perf-counter updates land 1 cycle after commit.
// Backpressure: an update commits only on cycles where ex_stall is low, so a held EX instruction commits exactly once.
//
// Ports:
//   clk, reset            core clock, asynchronous active-high reset
//   if_pc / if_pred_taken fetch-side lookup: MSB of the counter indexed by if_pc
//   ex_*                  EX-stage instruction: valid/stall, pc, funct3, branch/jump kind,
//                         ALU compare flags (zero, signed less, unsigned less), carried prediction
//   pc_sel                control transfer actually taken (jump, or branch resolved taken)
//   mispredict            conditional-branch outcome disagrees with ex_pred_taken
//   redirect/redirect_seq flush front end; redirect_seq selects refetch at ex_pc+4
//   branch_cnt/mispred_cnt saturating perf counters of committed and mispredicted branches

module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned IDX_LSB     = 2,
  parameter logic [1:0]  CTR_INIT    = 2'b01,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  // fetch-side lookup
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  // EX-stage instruction
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [2:0]       ex_fun3,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_zero,
  input  logic             ex_less,
  input  logic             ex_lessu,
  input  logic             ex_pred_taken,
  // resolution
  output logic             pc_sel,
  output logic             mispredict,
  output logic             redirect,
  output logic             redirect_seq,
  // perf counters
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  // funct3 encodings of the conditional branches
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             taken;
  logic             fun3_ok;
  logic             commit;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;

  // Only the index bits of either PC are looked at; the rest is intentionally ignored
  // (aliasing PCs share a counter).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_pc};

  assign if_idx = if_pc[IDX_LSB +: IDX_W];
  assign ex_idx = ex_pc[IDX_LSB +: IDX_W];

  // Reads come straight from the registered table: a same-cycle write to the
  // same entry is not bypassed, so fetch sees the pre-update value.
  assign if_pred_taken = bht_q[if_idx][1];

  // ------------------------------------------------------------------
  // Branch condition from the ALU compare flags
  // ------------------------------------------------------------------
  always_comb begin
    taken = 1'b0;
    unique case (ex_fun3)
      F3_BEQ:  taken =  ex_zero;
      F3_BNE:  taken = ~ex_zero;
      F3_BLT:  taken =  ex_less;
      F3_BGE:  taken = ~ex_less;
      F3_BLTU: taken =  ex_lessu;
      F3_BGEU: taken = ~ex_lessu;
      default: taken = 1'b0;   // funct3 2/3 are not branches
    endcase
  end

  assign fun3_ok = (ex_fun3 != 3'd2) && (ex_fun3 != 3'd3);

  // ------------------------------------------------------------------
  // Resolution outputs: combinational, gated by ex_valid but not by ex_stall,
  // so a stalled branch still holds the front end redirected.
  // A jump that also carries ex_branch is treated purely as a jump.
  // ------------------------------------------------------------------
  always_comb begin
    pc_sel       = ex_valid & (ex_jump | (ex_branch & taken));
    mispredict   = ex_valid & ex_branch & ~ex_jump & (taken != ex_pred_taken);
    redirect     = (ex_valid & ex_jump) | mispredict;
    redirect_seq = mispredict & ~taken;
  end

  assign commit = ex_valid & ~ex_stall & ex_branch & ~ex_jump & fun3_ok;

  // ------------------------------------------------------------------
  // Saturating 2-bit counter update
  // ------------------------------------------------------------------
  always_comb begin
    ctr_cur  = bht_q[ex_idx];
    ctr_next = ctr_cur;
    if (taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (commit) bht_d[ex_idx] = ctr_next;
  end

  // ------------------------------------------------------------------
  // Perf counters: stick at all-ones rather than wrap
  // ------------------------------------------------------------------
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (commit) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= CTR_INIT;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      bht_q         <= bht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit. Narrow perf counters so saturation is reachable.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are worked out by hand for each step.

module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic             ex_valid, ex_stall;
  logic [XLEN-1:0]  ex_pc;
  logic [2:0]       ex_fun3;
  logic             ex_branch, ex_jump, ex_zero, ex_less, ex_lessu, ex_pred_taken;
  logic             pc_sel, mispredict, redirect, redirect_seq;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int total = 0;
  int bad   = 0;

  branch_predict_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(64), .IDX_LSB(2), .CTR_INIT(2'b01), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_fun3(ex_fun3),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_zero(ex_zero), .ex_less(ex_less),
    .ex_lessu(ex_lessu), .ex_pred_taken(ex_pred_taken),
    .pc_sel(pc_sel), .mispredict(mispredict), .redirect(redirect), .redirect_seq(redirect_seq),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then give combinational logic time after new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_stall = 0; ex_pc = '0; ex_fun3 = 3'd0; ex_branch = 0; ex_jump = 0;
    ex_zero = 0; ex_less = 0; ex_lessu = 0; ex_pred_taken = 0;
  endtask

  task automatic br(input logic [31:0] pc, input logic [2:0] f3, input logic z,
                    input logic l, input logic lu, input logic pred);
    ex_valid = 1; ex_stall = 0; ex_pc = pc; ex_fun3 = f3; ex_branch = 1; ex_jump = 0;
    ex_zero = z; ex_less = l; ex_lessu = lu; ex_pred_taken = pred;
  endtask

  task automatic res(input string tag, input logic ps, input logic mp,
                     input logic rd, input logic rs);
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(ps));
    chk({tag, ".mispredict"}, 32'(mispredict), 32'(mp));
    chk({tag, ".redirect"}, 32'(redirect), 32'(rd));
    chk({tag, ".redirect_seq"}, 32'(redirect_seq), 32'(rs));
  endtask

  task automatic cnts(input string tag, input int b, input int m);
    chk({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(b));
    chk({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(m));
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    chk({tag, ".if_pred_taken"}, 32'(if_pred_taken), 32'(exp));
  endtask

  initial begin
    // ---------------- reset ----------------
    reset = 1; idle(); if_pc = 32'h100;
    #1;
    chk("rst.if_pred_taken", 32'(if_pred_taken), 32'd0);
    res("rst", 0, 0, 0, 0);
    cnts("rst", 0, 0);
    tick(); tick();
    reset = 0;

    // ---------------- training at 0x100 (idx 0) ----------------
    br(32'h100, 3'd0, 1, 0, 0, 0);            // BEQ taken, predicted not taken
    #1;
    res("beq1", 1, 1, 1, 0);
    chk("beq1.no_bypass", 32'(if_pred_taken), 32'd0);
    tick();                                   // ctr 01 -> 10
    chk("beq1.after_pred", 32'(if_pred_taken), 32'd1);
    cnts("beq1", 1, 1);
    ex_pred_taken = 1;                        // second taken BEQ, predicted taken
    #1;
    res("beq2", 1, 0, 0, 0);
    tick();                                   // ctr 10 -> 11
    chk("beq2.pred", 32'(if_pred_taken), 32'd1);
    cnts("beq2", 2, 1);

    // BNE with zero=1: not taken, predicted taken -> refetch sequential
    br(32'h100, 3'd1, 1, 0, 0, 1);
    #1;
    res("bne1", 0, 1, 1, 1);
    tick();                                   // 11 -> 10
    chk("bne1.pred", 32'(if_pred_taken), 32'd1);
    tick();                                   // 10 -> 01
    chk("bne2.pred", 32'(if_pred_taken), 32'd0);
    tick();                                   // 01 -> 00
    cnts("bne3", 5, 4);
    ex_pred_taken = 0;
    #1;
    res("bne4", 0, 0, 0, 0);
    tick();                                   // stays 00
    cnts("bne4", 6, 4);
    // One taken commit: from 00 this reaches 01 (still not taken); a wrap would show 1
    br(32'h100, 3'd0, 1, 0, 0, 0);
    tick();
    chk("sat_low.pred", 32'(if_pred_taken), 32'd0);
    cnts("sat_low", 7, 5);

    // ---------------- compare flavours at 0x104 (idx 1) ----------------
    br(32'h104, 3'd4, 0, 1, 0, 0);            // BLT, less=1 -> taken, mispredicted
    #1;
    res("blt", 1, 1, 1, 0);
    tick();
    cnts("blt", 8, 6);
    br(32'h104, 3'd7, 0, 0, 0, 1);            // BGEU, lessu=0 -> taken, correct
    #1;
    res("bgeu", 1, 0, 0, 0);
    tick();
    cnts("bgeu", 9, 6);
    br(32'h104, 3'd6, 0, 0, 0, 1);            // BLTU, lessu=0 -> not taken, mispredicted
    #1;
    res("bltu", 0, 1, 1, 1);
    tick();                                   // idx1: 01->10->11->10
    cnts("bltu", 10, 7);
    idle();
    pred_at("idx1", 32'h104, 1);

    // ---------------- stall at 0x108 (idx 2) ----------------
    if_pc = 32'h108;
    br(32'h108, 3'd0, 1, 0, 0, 0);
    ex_stall = 1;
    #1;
    res("stall", 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.pred", 32'(if_pred_taken), 32'd0);
      cnts("stall", 10, 7);
    end
    ex_stall = 0;
    tick();                                   // idx2: 01 -> 10
    chk("unstall.pred", 32'(if_pred_taken), 32'd1);
    cnts("unstall", 11, 8);
    idle();
    tick();
    cnts("unstall.once", 11, 8);

    // ---------------- JAL with branch also set ----------------
    br(32'h108, 3'd0, 0, 0, 0, 0);            // branch part would resolve not taken
    ex_jump = 1;
    #1;
    res("jal", 1, 0, 1, 0);
    tick();
    chk("jal.pred", 32'(if_pred_taken), 32'd1);
    cnts("jal", 11, 8);

    // ---------------- funct3 = 2: not a branch ----------------
    br(32'h108, 3'd2, 0, 0, 0, 0);
    #1;
    res("f3_2", 0, 0, 0, 0);
    tick();
    chk("f3_2.pred", 32'(if_pred_taken), 32'd1);
    cnts("f3_2", 11, 8);

    // ---------------- perf counter saturation ----------------
    br(32'h10C, 3'd0, 0, 0, 0, 0);            // correctly predicted not taken
    for (int i = 0; i < 3; i++) tick();
    cnts("sat_m1", 14, 8);
    tick(); tick();
    cnts("sat_top", 15, 8);

    // ---------------- reset mid-run ----------------
    br(32'h108, 3'd0, 1, 0, 0, 0);            // pending taken commit to idx2
    if_pc = 32'h108;
    #1;
    reset = 1;
    #1;
    chk("mid_rst.pred", 32'(if_pred_taken), 32'd0);
    cnts("mid_rst", 0, 0);
    res("mid_rst", 1, 1, 1, 0);               // resolution still follows inputs
    pred_at("mid_rst.idx1", 32'h104, 0);
    tick();
    idle();
    reset = 0;
    tick();
    pred_at("post_rst.idx2", 32'h108, 0);
    cnts("post_rst", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
